// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer feeding a valid/ready stream via a 2-entry skid buffer; rinc -> m_valid latency 1 cycle.
// Backpressure: FIFO pops stop when both skid entries are full. Optional counter enabled by FIFO_RD_CNT_EN.
module fifo_rd_stream #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 rempty,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 rinc,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  input  logic                 flush,
  output logic [CNT_W-1:0]     rd_count
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] e0_q, e0_d, e1_q, e1_d;
  logic                 valid_q, valid_d;
  logic                 pop, take;

  // pop depends only on FIFO/skid state so rinc has no combinational path from m_ready
  assign pop  = !rempty && (cnt_q != 2'd2) && (state_q == RUN) && !flush;
  assign take = valid_q && m_ready;
  assign rinc = !rrst && ((state_q == DRAIN) ? !rempty : pop);

  assign m_valid = valid_q;
  assign m_data  = e0_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = DRAIN;
          cnt_d   = 2'd0;
        end else begin
          if (take) e0_d = e1_q;
          // after any shift, the first free slot is at index cnt - take
          if (pop) begin
            if ((cnt_q - {1'b0, take}) == 2'd0) e0_d = rdata;
            else                                e1_d = rdata;
          end
          cnt_d = cnt_q + {1'b0, pop} - {1'b0, take};
        end
      end
      DRAIN: begin
        if (!flush && rempty) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      valid_q <= valid_d;
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] rd_count_q, rd_count_d;

  assign rd_count_d = take ? rd_count_q + CNT_W'(1) : rd_count_q;
  assign rd_count   = rd_count_q;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) rd_count_q <= '0;
    else      rd_count_q <= rd_count_d;
  end
`else
  assign rd_count = '0;
`endif

endmodule
